// File: rtl/tt_pad_pkg.sv
// Shared types and helpers for the tile pad controller.
package tt_pad_pkg;

    localparam int unsigned PULL_W = 2;

    typedef enum logic [1:0] {
        PAD_OFF = 2'd0,
        PAD_IN  = 2'd1,
        PAD_OUT = 2'd2,
        PAD_OD  = 2'd3
    } pad_mode_t;

    typedef enum logic {
        ST_STEADY = 1'b0,
        ST_TURN   = 1'b1
    } pad_state_t;

    // Pulls are {PU,PD}.
    typedef struct packed {
        pad_mode_t         mode;
        logic [PULL_W-1:0] pull;
        logic              sl;
        logic              cs;
        logic [PULL_W-1:0] hclk_pull;
    } pad_cfg_t;

    // Both pulls enabled together is illegal on the pad; fall back to none.
    function automatic logic [PULL_W-1:0] sanitize_pull(input logic [PULL_W-1:0] pull);
        return (pull == 2'b11) ? 2'b00 : pull;
    endfunction

endpackage

// File: rtl/tt_pad_in_filter.sv
// Pad input synchronizer, run-length debounce filter and edge pulses.
module tt_pad_in_filter
    import tt_pad_pkg::*;
#(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic freeze,
    input  logic pad_y,
    output logic din,
    output logic din_rise,
    output logic din_fall
);

    localparam int unsigned CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN + 1) : 1;

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchronizer; filter accepts a new level after FILT_LEN disagreeing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            cnt      <= '0;
            din      <= 1'b0;
            din_rise <= 1'b0;
            din_fall <= 1'b0;
        end else begin
            sync1    <= pad_y;
            sync2    <= sync1;
            din_rise <= 1'b0;
            din_fall <= 1'b0;
            if (freeze || (sync2 == din)) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(FILT_LEN - 1)) begin
                cnt      <= '0;
                din      <= sync2;
                din_rise <= sync2;
                din_fall <= ~sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/tt_pad_ctrl.sv
// Pad controller: mode sequencing with high-Z turnaround and registered pad controls.
module tt_pad_ctrl
    import tt_pad_pkg::*;
#(
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned FILT_LEN    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [1:0] cfg_mode,
    input  logic [1:0] cfg_pull,
    input  logic       cfg_sl,
    input  logic       cfg_cs,
    input  logic [1:0] cfg_hclk_pull,
    input  logic       dout,
    output logic       din,
    output logic       din_rise,
    output logic       din_fall,
    input  logic       hclk_Y,
    output logic       hclk_PD,
    output logic       hclk_PU,
    input  logic       hsig_Y,
    output logic       hsig_A,
    output logic       hsig_OE,
    output logic       hsig_IE,
    output logic       hsig_SL,
    output logic       hsig_CS,
    output logic       hsig_PD,
    output logic       hsig_PU
);

    localparam int unsigned CNT_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

    pad_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    pad_mode_t        mode_q, mode_d;
    pad_cfg_t         cfg_q, cfg_d;
    pad_cfg_t         cfg_in;
    logic             hs;
    logic             a_d, oe_d, ie_d;
    logic             freeze;
    logic             unused_hclk_y;

    // The clock pad input is reserved.
    assign unused_hclk_y = hclk_Y;

    // Sanitized view of the incoming configuration word.
    always_comb begin
        cfg_in.mode      = pad_mode_t'(cfg_mode);
        cfg_in.pull      = sanitize_pull(cfg_pull);
        cfg_in.sl        = cfg_sl;
        cfg_in.cs        = cfg_cs;
        cfg_in.hclk_pull = sanitize_pull(cfg_hclk_pull);
    end

    assign hs = cfg_valid & cfg_ready;

    // FSM state, turnaround counter, current mode and latched configuration.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_STEADY;
            cnt_q   <= '0;
            mode_q  <= PAD_OFF;
            cfg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            cfg_q   <= cfg_d;
        end
    end

    // Next state and next pad-drive values; outputs follow the next state so they flop at the same edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        cfg_d   = cfg_q;
        a_d     = 1'b0;
        oe_d    = 1'b0;
        ie_d    = 1'b0;

        case (state_q)
            ST_STEADY: begin
                if (hs) begin
                    cfg_d = cfg_in;
                    if (cfg_in.mode != mode_q) begin
                        state_d = ST_TURN;
                        cnt_d   = CNT_W'(TURN_CYCLES - 1);
                    end
                end
            end
            ST_TURN: begin
                if (cnt_q == '0) begin
                    state_d = ST_STEADY;
                    mode_d  = cfg_q.mode;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_STEADY;
        endcase

        if (state_d == ST_STEADY) begin
            case (mode_d)
                PAD_OFF: begin
                    oe_d = 1'b0;
                    ie_d = 1'b0;
                end
                PAD_IN: begin
                    ie_d = 1'b1;
                end
                PAD_OUT: begin
                    oe_d = 1'b1;
                    ie_d = 1'b1;
                    a_d  = dout;
                end
                PAD_OD: begin
                    oe_d = ~dout;
                    ie_d = 1'b1;
                end
                default: begin
                    oe_d = 1'b0;
                    ie_d = 1'b0;
                end
            endcase
        end
    end

    // Registered pad controls and handshake ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_ready <= 1'b1;
            hsig_A    <= 1'b0;
            hsig_OE   <= 1'b0;
            hsig_IE   <= 1'b0;
            hsig_SL   <= 1'b0;
            hsig_CS   <= 1'b0;
            hsig_PU   <= 1'b0;
            hsig_PD   <= 1'b0;
            hclk_PU   <= 1'b0;
            hclk_PD   <= 1'b0;
        end else begin
            cfg_ready <= (state_d == ST_STEADY);
            hsig_A    <= a_d;
            hsig_OE   <= oe_d;
            hsig_IE   <= ie_d;
            hsig_SL   <= cfg_d.sl;
            hsig_CS   <= cfg_d.cs;
            hsig_PU   <= cfg_d.pull[1];
            hsig_PD   <= cfg_d.pull[0];
            hclk_PU   <= cfg_d.hclk_pull[1];
            hclk_PD   <= cfg_d.hclk_pull[0];
        end
    end

    // Input filter holds while the pad input buffer is off or a turnaround is in progress.
    assign freeze = ~hsig_IE | (state_q == ST_TURN);

    tt_pad_in_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_in_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .freeze   (freeze),
        .pad_y    (hsig_Y),
        .din      (din),
        .din_rise (din_rise),
        .din_fall (din_fall)
    );

endmodule

// File: tb/tb_tt_pad_ctrl.sv
// Self-checking bench for tt_pad_ctrl against a behavioural pad model.
module tb_tt_pad_ctrl;

    localparam int TC = 2;
    localparam int FL = 3;

    localparam logic [1:0] M_OFF = 2'd0;
    localparam logic [1:0] M_IN  = 2'd1;
    localparam logic [1:0] M_OUT = 2'd2;
    localparam logic [1:0] M_OD  = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_mode = 2'd0;
    logic [1:0] cfg_pull = 2'd0;
    logic       cfg_sl = 1'b0;
    logic       cfg_cs = 1'b0;
    logic [1:0] cfg_hclk_pull = 2'd0;
    logic       dout = 1'b0;
    logic       din, din_rise, din_fall;
    logic       hclk_Y = 1'b0;
    logic       hclk_PD, hclk_PU;
    logic       hsig_Y = 1'b0;
    logic       hsig_A, hsig_OE, hsig_IE, hsig_SL, hsig_CS, hsig_PD, hsig_PU;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tt_pad_ctrl #(
        .TURN_CYCLES (TC),
        .FILT_LEN    (FL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_mode      (cfg_mode),
        .cfg_pull      (cfg_pull),
        .cfg_sl        (cfg_sl),
        .cfg_cs        (cfg_cs),
        .cfg_hclk_pull (cfg_hclk_pull),
        .dout          (dout),
        .din           (din),
        .din_rise      (din_rise),
        .din_fall      (din_fall),
        .hclk_Y        (hclk_Y),
        .hclk_PD       (hclk_PD),
        .hclk_PU       (hclk_PU),
        .hsig_Y        (hsig_Y),
        .hsig_A        (hsig_A),
        .hsig_OE       (hsig_OE),
        .hsig_IE       (hsig_IE),
        .hsig_SL       (hsig_SL),
        .hsig_CS       (hsig_CS),
        .hsig_PD       (hsig_PD),
        .hsig_PU       (hsig_PU)
    );

    // Reference model state: mode in force, TURN cycles still to show, Y history, disagreeing run length.
    logic [1:0] m_mode = M_OFF;
    logic [1:0] m_pend = M_OFF;
    int         m_turn = 0;
    logic       m_y1 = 1'b0;
    logic       m_y2 = 1'b0;
    int         m_run = 0;
    logic       e_ready = 1'b1, e_din = 1'b0, e_rise = 1'b0, e_fall = 1'b0;
    logic       e_a = 1'b0, e_oe = 1'b0, e_ie = 1'b0, e_sl = 1'b0, e_cs = 1'b0;
    logic [1:0] e_pull = 2'b00, e_hpull = 2'b00;
    logic       frz;

    logic [12:0] dut_vec, e_vec;
    assign dut_vec = {cfg_ready, din, din_rise, din_fall, hclk_PD, hclk_PU,
                      hsig_A, hsig_OE, hsig_IE, hsig_SL, hsig_CS, hsig_PD, hsig_PU};
    assign e_vec   = {e_ready, e_din, e_rise, e_fall, e_hpull[0], e_hpull[1],
                      e_a, e_oe, e_ie, e_sl, e_cs, e_pull[0], e_pull[1]};

    // Model advances once per rising edge using the inputs held stable since the previous falling edge.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_mode = M_OFF; m_pend = M_OFF; m_turn = 0;
                m_y1 = 1'b0; m_y2 = 1'b0; m_run = 0;
                e_ready = 1'b1; e_din = 1'b0; e_rise = 1'b0; e_fall = 1'b0;
                e_a = 1'b0; e_oe = 1'b0; e_ie = 1'b0; e_sl = 1'b0; e_cs = 1'b0;
                e_pull = 2'b00; e_hpull = 2'b00;
            end else begin
                frz = !e_ie || (m_turn != 0);
                e_rise = 1'b0;
                e_fall = 1'b0;
                if (frz || (m_y2 == e_din)) begin
                    m_run = 0;
                end else begin
                    m_run = m_run + 1;
                    if (m_run == FL) begin
                        e_din  = m_y2;
                        e_rise = m_y2;
                        e_fall = !m_y2;
                        m_run  = 0;
                    end
                end
                m_y2 = m_y1;
                m_y1 = hsig_Y;

                if (cfg_valid && e_ready) begin
                    e_pull  = (cfg_pull == 2'b11) ? 2'b00 : cfg_pull;
                    e_hpull = (cfg_hclk_pull == 2'b11) ? 2'b00 : cfg_hclk_pull;
                    e_sl    = cfg_sl;
                    e_cs    = cfg_cs;
                    if (cfg_mode != m_mode) begin
                        m_pend = cfg_mode;
                        m_turn = TC;
                    end
                end else if (m_turn != 0) begin
                    m_turn = m_turn - 1;
                    if (m_turn == 0) m_mode = m_pend;
                end

                e_ready = (m_turn == 0);
                e_a = 1'b0; e_oe = 1'b0; e_ie = 1'b0;
                if (m_turn == 0) begin
                    if (m_mode == M_IN)  begin e_ie = 1'b1; end
                    if (m_mode == M_OUT) begin e_ie = 1'b1; e_oe = 1'b1; e_a = dout; end
                    if (m_mode == M_OD)  begin e_ie = 1'b1; e_oe = !dout; end
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        hsig_Y = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (dut_vec !== 13'b1_0000_0000_0000) begin
            fails++;
            $display("FAIL reset_state got %b exp %b", dut_vec, 13'b1_0000_0000_0000);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (din !== 1'b0 || dut_vec !== e_vec) begin
            fails++;
            $display("FAIL reset_release got %b exp %b", dut_vec, e_vec);
        end
    endtask

    task automatic test_off_to_out();
        hsig_Y = 1'b0;
        dout = 1'b1;
        cfg_valid = 1'b1; cfg_mode = M_OUT; cfg_pull = 2'b00;
        cfg_sl = 1'b1; cfg_cs = 1'b0; cfg_hclk_pull = 2'b01;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            tests++;
            if (dut_vec !== e_vec) begin
                fails++;
                $display("FAIL off_to_out_model c=%0d got %b exp %b", c, dut_vec, e_vec);
            end
            tests++;
            if (hsig_OE !== (c == 3) || hsig_A !== (c == 3) || cfg_ready !== (c == 3)
                || hsig_SL !== 1'b1 || hclk_PD !== 1'b1) begin
                fails++;
                $display("FAIL off_to_out_timing c=%0d got oe=%b a=%b rdy=%b sl=%b hpd=%b", c,
                         hsig_OE, hsig_A, cfg_ready, hsig_SL, hclk_PD);
            end
        end
    endtask

    task automatic test_same_mode_pull();
        cfg_valid = 1'b1; cfg_mode = M_OUT; cfg_pull = 2'b10;
        @(negedge clk);
        cfg_valid = 1'b0;
        tests++;
        if (hsig_PU !== 1'b1 || hsig_PD !== 1'b0 || hsig_OE !== 1'b1 || cfg_ready !== 1'b1
            || dut_vec !== e_vec) begin
            fails++;
            $display("FAIL same_mode_pu got %b exp %b", dut_vec, e_vec);
        end
        cfg_valid = 1'b1; cfg_pull = 2'b11; cfg_hclk_pull = 2'b11;
        @(negedge clk);
        cfg_valid = 1'b0;
        tests++;
        if (hsig_PU !== 1'b0 || hsig_PD !== 1'b0 || hclk_PU !== 1'b0 || hclk_PD !== 1'b0
            || hsig_OE !== 1'b1 || dut_vec !== e_vec) begin
            fails++;
            $display("FAIL same_mode_pull11 got %b exp %b", dut_vec, e_vec);
        end
        dout = 1'b0;
        @(negedge clk);
        tests++;
        if (hsig_A !== 1'b0 || hsig_OE !== 1'b1 || dut_vec !== e_vec) begin
            fails++;
            $display("FAIL out_dout_track got %b exp %b", dut_vec, e_vec);
        end
    endtask

    task automatic test_od();
        cfg_valid = 1'b1; cfg_mode = M_OD; dout = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            dout = (c == 1);
            tests++;
            if (dut_vec !== e_vec || hsig_OE !== (c == 3) || hsig_A !== 1'b0) begin
                fails++;
                $display("FAIL od_enter c=%0d got %b exp %b", c, dut_vec, e_vec);
            end
        end
        dout = 1'b1;
        @(negedge clk);
        tests++;
        if (hsig_OE !== 1'b0 || hsig_A !== 1'b0 || hsig_IE !== 1'b1 || dut_vec !== e_vec) begin
            fails++;
            $display("FAIL od_release got %b exp %b", dut_vec, e_vec);
        end
    endtask

    task automatic test_in_filter();
        hsig_Y = 1'b0;
        cfg_valid = 1'b1; cfg_mode = M_IN;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            tests++;
            if (dut_vec !== e_vec) begin
                fails++;
                $display("FAIL in_enter c=%0d got %b exp %b", c, dut_vec, e_vec);
            end
        end
        hsig_Y = 1'b1;
        repeat (2) @(negedge clk);
        hsig_Y = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            tests++;
            if (din !== 1'b0 || din_rise !== 1'b0 || dut_vec !== e_vec) begin
                fails++;
                $display("FAIL in_glitch c=%0d got %b exp %b", c, dut_vec, e_vec);
            end
        end
        for (int v = 1; v >= 0; v--) begin
            hsig_Y = 1'(v);
            for (int c = 1; c <= 6; c++) begin
                @(negedge clk);
                tests++;
                if (din !== ((c >= 5) ? 1'(v) : 1'(1 - v))
                    || din_rise !== (c == 5 && v == 1) || din_fall !== (c == 5 && v == 0)
                    || dut_vec !== e_vec) begin
                    fails++;
                    $display("FAIL in_edge v=%0d c=%0d got %b exp %b", v, c, dut_vec, e_vec);
                end
            end
        end
    endtask

    task automatic test_reset_mid_turn();
        cfg_valid = 1'b1; cfg_mode = M_OUT;
        repeat (3) @(negedge clk);
        cfg_valid = 1'b1; cfg_mode = M_IN;
        @(negedge clk);
        cfg_valid = 1'b0;
        rst_n = 1'b0;
        tests++;
        if (cfg_ready !== 1'b0 || hsig_OE !== 1'b0 || hsig_IE !== 1'b0) begin
            fails++;
            $display("FAIL mid_turn_pre got rdy=%b oe=%b ie=%b", cfg_ready, hsig_OE, hsig_IE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tests++;
        if (dut_vec !== 13'b1_0000_0000_0000) begin
            fails++;
            $display("FAIL mid_turn_reset got %b exp %b", dut_vec, 13'b1_0000_0000_0000);
        end
        repeat (3) begin
            @(negedge clk);
            tests++;
            if (hsig_IE !== 1'b0 || hsig_OE !== 1'b0 || cfg_ready !== 1'b1 || dut_vec !== e_vec) begin
                fails++;
                $display("FAIL mid_turn_discard got %b exp %b", dut_vec, e_vec);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            rst_n         = ($urandom_range(0, 99) != 0);
            cfg_valid     = ($urandom_range(0, 3) == 0);
            cfg_mode      = 2'($urandom_range(0, 3));
            cfg_pull      = 2'($urandom_range(0, 3));
            cfg_hclk_pull = 2'($urandom_range(0, 3));
            cfg_sl        = 1'($urandom_range(0, 1));
            cfg_cs        = 1'($urandom_range(0, 1));
            dout          = 1'($urandom_range(0, 1));
            hclk_Y        = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) hsig_Y = ~hsig_Y;
            @(negedge clk);
            tests++;
            if (dut_vec !== e_vec) begin
                fails++;
                $display("FAIL random c=%0d got %b exp %b", c, dut_vec, e_vec);
            end
        end
        rst_n = 1'b1;
        cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_off_to_out();
        test_same_mode_pull();
        test_od();
        test_in_filter();
        test_reset_mid_turn();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
